mem_access: RTL
===============

Name: mem_access

Overview:
- MEM pipeline stage. Sits between the EX/MEM pipeline register and the MEM/WB register; its mem_wdata, mem_wd and mem_wreg outputs feed MEM/WB directly.
- Non-memory instructions pass through combinationally.
- Loads and stores run a handshake with the data-memory port, hold the pipeline with stall_req until the access completes, and format load data by byte or halfword.
- Misaligned accesses and bus timeouts become a suppressed writeback plus an error pulse.

Parameters:
- TIMEOUT_CYCLES, 16, number of WAIT cycles without dmem_ack before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- ex_wdata  in  32  ALU result or link value for non-memory ops.
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  register write enable.
- ex_memop  in  4  operation: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 are treated as none.
- ex_memaddr  in  32  effective byte address.
- ex_sdata  in  32  store data (rt value).
- mem_wdata  out  32  writeback data to MEM/WB.
- mem_wd  out  5  writeback address to MEM/WB.
- mem_wreg  out  1  writeback enable to MEM/WB.
- stall_req  out  1  freeze request to pipeline control; ex_* inputs stay stable while it is 1.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address: ex_memaddr with bits [1:0] forced to 0.
- dmem_be  out  4  byte enables; bit i enables byte lane [8i+7:8i] (little-endian).
- dmem_wdata  out  32  store data replicated to lanes: SB = {4{b}}, SH = {2{h}}.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  load word.
- align_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a timeout.

Behaviour:
- States:
  - IDLE: no access in progress; accepts a new op.
  - WAIT: request outstanding, waiting for dmem_ack.
  - DONE: access finished; result presented.
- Reset (rst=0 at posedge):
  - state = IDLE; timeout counter = 0; rdata_q = 0; error flags = 0.
  - While rst=0: all outputs are 0 (mem_wd = 5'd0, mem_wdata = 32'd0); dmem_req = 0.
- Reset mid-access: the request is dropped immediately; a late dmem_ack is ignored.
- IDLE, ex_memop none:
  - mem_wdata = ex_wdata, mem_wd = ex_wd, mem_wreg = ex_wreg, same cycle.
  - stall_req = 0; dmem_req = 0.
- Misalignment: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - In IDLE: align_err = 1 for that cycle; mem_wreg = 0; no request issued; stall_req = 0; stay in IDLE.
- IDLE, aligned memory op:
  - dmem_req = 1, stall_req = 1, mem_wreg = 0 (bubble). Next state WAIT; counter cleared.
  - An ack in this first cycle is not sampled.
- WAIT:
  - dmem_req = 1, stall_req = 1, mem_wreg = 0.
  - On dmem_ack: latch dmem_rdata into rdata_q; go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES: pulse bus_err, set the abort flag, go to DONE.
- DONE:
  - stall_req = 0; dmem_req = 0; the MEM/WB register captures the outputs at this edge. Next state IDLE.
  - Loads: mem_wreg = ex_wreg & ~abort; mem_wd = ex_wd; mem_wdata is formatted from rdata_q as follows.
  - LB/LBU: select lane addr[1:0]; sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select lane addr[1] (0 = [15:0]); sign-extend or zero-extend.
  - LW: full word.
  - Stores: mem_wreg = 0.
- Store byte enables: SB = 4'b0001 << addr[1:0]; SH = addr[1] ? 4'b1100 : 4'b0011; SW = 4'b1111. dmem_be = 0 for loads.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op with ack on the first WAIT cycle: 3 cycles total (IDLE, WAIT, DONE), i.e. a 2-cycle stall.
  - In general the stall lasts 1 + (WAIT cycles) cycles.
- dmem_addr, dmem_we, dmem_be and dmem_wdata are stable for the whole time dmem_req = 1.

Test Plan:
- Pass-through: ex_memop = 0, ex_wdata = 32'h1234_5678, ex_wd = 5'd3, ex_wreg = 1 -> same-cycle mem_wdata = 32'h1234_5678, mem_wd = 3, mem_wreg = 1, stall_req = 0, dmem_req = 0.
- Loads: LB at addr 0x103, dmem_rdata = 32'h80AA_BBCC, ack on the first WAIT cycle -> stall_req high for 2 cycles, then DONE gives mem_wdata = 32'hFFFF_FF80. Same case with LBU gives 32'h0000_0080. LH at 0x102 gives 32'hFFFF_80AA.
- Stores:
  - SH at 0x206, data 32'h0000_BEEF -> dmem_we = 1, dmem_addr = 0x204, dmem_be = 4'b1100, dmem_wdata = 32'hBEEF_BEEF, mem_wreg = 0.
  - SB at 0x201 -> dmem_be = 4'b0010.
- Misaligned: LW at 0x302 -> align_err pulses once, dmem_req stays 0, mem_wreg = 0, stall_req = 0.
- Timeout: TIMEOUT_CYCLES = 4, LW, no ack -> 4 WAIT cycles, bus_err pulse, DONE with mem_wreg = 0, then IDLE.
- Reset mid-WAIT: rst = 0 for one edge while in WAIT -> next cycle all outputs 0 and state IDLE; a late dmem_ack is ignored.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between the EX/MEM and MEM/WB registers.
//
// Non-memory ops pass straight through combinationally. Loads and stores
// run a req/ack handshake with the data-memory port, hold the pipeline
// with stall_req until the access finishes, and present the (formatted)
// result for one cycle in DONE. Misaligned accesses and bus timeouts
// suppress the writeback and raise a one-cycle error pulse.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   ex_wdata/ex_wd/ex_wreg   writeback data/address/enable from EX/MEM
//   ex_memop                 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
//   ex_memaddr, ex_sdata     effective byte address, store data
//   mem_wdata/mem_wd/mem_wreg writeback to MEM/WB
//   stall_req                freeze request to pipeline control
//   dmem_*                   data-memory request port
//   align_err, bus_err       one-cycle error pulses
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_memaddr,
  input  logic [31:0] ex_sdata,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        abort_q, abort_d;

  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] sdata_calc;
  logic [31:0] load_data;
  logic [7:0]  cnt_inc;

  // ---------------------------------------------------------------------------
  // Operation decode (ex_* stay stable while stall_req is high)
  // ---------------------------------------------------------------------------
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_calc    = 4'b0000;
    sdata_calc = 32'd0;
    case (ex_memop)
      OpLb, OpLbu: is_load = 1'b1;
      OpLh, OpLhu: begin
        is_load    = 1'b1;
        misaligned = ex_memaddr[0];
      end
      OpLw: begin
        is_load    = 1'b1;
        misaligned = |ex_memaddr[1:0];
      end
      OpSb: begin
        is_store   = 1'b1;
        be_calc    = 4'b0001 << ex_memaddr[1:0];
        sdata_calc = {4{ex_sdata[7:0]}};
      end
      OpSh: begin
        is_store   = 1'b1;
        misaligned = ex_memaddr[0];
        be_calc    = ex_memaddr[1] ? 4'b1100 : 4'b0011;
        sdata_calc = {2{ex_sdata[15:0]}};
      end
      OpSw: begin
        is_store   = 1'b1;
        misaligned = |ex_memaddr[1:0];
        be_calc    = 4'b1111;
        sdata_calc = ex_sdata;
      end
      default: ;  // 0 and 9..15 behave as no memory op
    endcase
  end

  assign is_mem  = is_load | is_store;
  assign cnt_inc = cnt_q + 8'd1;

  // ---------------------------------------------------------------------------
  // Load data formatting from the latched word
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    unique case (ex_memaddr[1:0])
      2'd0:    lane_b = rdata_q[7:0];
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
    lane_h = ex_memaddr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ex_memop)
      OpLb:    load_data = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_data = {24'd0, lane_b};
      OpLh:    load_data = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_data = {16'd0, lane_h};
      default: load_data = rdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        // dmem_ack is deliberately not looked at in the request's first cycle
        if (is_mem && !misaligned) begin
          state_d = StWait;
          cnt_d   = 8'd0;
          abort_d = 1'b0;
        end
      end
      StWait: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutVal) begin
            abort_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic; everything is held at zero while reset is asserted
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wdata  = 32'd0;
    mem_wd     = 5'd0;
    mem_wreg   = 1'b0;
    stall_req  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'd0;
    align_err  = 1'b0;
    bus_err    = 1'b0;
    if (rst) begin
      mem_wdata  = ex_wdata;
      mem_wd     = ex_wd;
      // Address/strobe/data come straight from the frozen ex_* inputs, so they
      // stay stable for as long as the request is held.
      dmem_we    = is_store;
      dmem_addr  = {ex_memaddr[31:2], 2'b00};
      dmem_be    = be_calc;
      dmem_wdata = sdata_calc;
      unique case (state_q)
        StIdle: begin
          if (!is_mem) begin
            mem_wreg = ex_wreg;
          end else if (misaligned) begin
            align_err = 1'b1;
          end else begin
            dmem_req  = 1'b1;
            stall_req = 1'b1;
          end
        end
        StWait: begin
          dmem_req  = 1'b1;
          stall_req = 1'b1;
        end
        StDone: begin
          bus_err = abort_q;
          if (is_load) begin
            mem_wreg  = ex_wreg & ~abort_q;
            mem_wdata = load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
